// File: rtl/led_ser_pkg.sv
// Shared types and helpers for the LED shift-register serializer.
package led_ser_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      SHIFT,
      LATCH
   } state_t;

   // Width of a counter that must hold 0..n-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/led_ser_tick.sv
// Phase tick generator: pulses o_tick on the last cycle of every CLK_DIV-cycle phase.
module led_ser_tick #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   output logic o_tick
);
   import led_ser_pkg::*;

   localparam int unsigned   CW   = cnt_width(CLK_DIV);
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr || (r_cnt == LAST)) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/led_serializer.sv
// Serializes a parallel frame into an external shift register:
// clear pulse, DATA_BITS clocked bits, then a latch strobe and a done pulse.
module led_serializer #(
   parameter int unsigned DATA_BITS = 16,
   parameter int unsigned CLK_DIV   = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [DATA_BITS-1:0] pdata,
   input  logic                 dir,
   output logic                 busy,
   output logic                 done,
   output logic                 sclk,
   output logic                 sclrn,
   output logic                 sout,
   output logic                 en
);
   import led_ser_pkg::*;

   localparam int unsigned   BW       = cnt_width(DATA_BITS);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   state_t               r_state;
   logic [DATA_BITS-1:0] r_shreg;
   logic                 r_dir;
   logic [BW-1:0]        r_bit;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_sclk;
   logic                 r_sclrn;
   logic                 r_sout;
   logic                 r_en;

   logic                 w_tick;
   logic                 w_clr;
   logic                 w_head;
   logic                 w_last;
   logic [DATA_BITS-1:0] w_shifted;

   always_comb begin
      w_head    = r_dir ? r_shreg[0] : r_shreg[DATA_BITS-1];
      w_shifted = r_dir ? {1'b0, r_shreg[DATA_BITS-1:1]}
                        : {r_shreg[DATA_BITS-2:0], 1'b0};
      w_last    = (r_bit == LAST_BIT);
      // Tick-driven transitions wrap the divider on their own; the two
      // non-tick transitions (accept, latch exit) need an explicit clear.
      w_clr     = (r_state == IDLE) || ((r_state == LATCH) && !r_en);
   end

   led_ser_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_clr),
      .o_tick (w_tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_shreg <= '0;
         r_dir   <= 1'b0;
         r_bit   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_sclk  <= 1'b0;
         r_sclrn <= 1'b1;
         r_sout  <= 1'b0;
         r_en    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_shreg <= pdata;
                  r_dir   <= dir;
                  r_bit   <= '0;
                  r_busy  <= 1'b1;
                  r_sclrn <= 1'b0;
                  r_state <= CLEAR;
               end
            end
            CLEAR: begin
               if (w_tick) begin
                  r_sclrn <= 1'b1;
                  r_sout  <= w_head;
                  r_shreg <= w_shifted;
                  r_state <= SHIFT;
               end
            end
            SHIFT: begin
               if (w_tick) begin
                  if (!r_sclk) begin
                     r_sclk <= 1'b1;
                  end else begin
                     r_sclk <= 1'b0;
                     if (w_last) begin
                        r_sout  <= 1'b0;
                        r_bit   <= '0;
                        r_en    <= 1'b1;
                        r_state <= LATCH;
                     end else begin
                        r_bit   <= r_bit + 1'b1;
                        r_sout  <= w_head;
                        r_shreg <= w_shifted;
                     end
                  end
               end
            end
            LATCH: begin
               // One quiet cycle after the strobe so done lands after en falls.
               if (!r_en) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= IDLE;
               end else if (w_tick) begin
                  r_en <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy  = r_busy;
   assign done  = r_done;
   assign sclk  = r_sclk;
   assign sclrn = r_sclrn;
   assign sout  = r_sout;
   assign en    = r_en;

endmodule

// File: tb/tb_led_serializer.sv
// Bench for led_serializer: two instances (8-bit/div-2 and 16-bit/div-1)
// checked frame by frame against bit order and timing derived from the frame rules.
module tb_led_serializer;

   logic       clk;
   logic       rst_a, rst_b;
   logic       start_a, start_b;
   logic [7:0] pdata_a;
   logic [15:0] pdata_b;
   logic       dir_a, dir_b;
   logic       busy_a, done_a, sclk_a, sclrn_a, sout_a, en_a;
   logic       busy_b, done_b, sclk_b, sclrn_b, sout_b, en_b;

   int         sel;
   logic       m_busy, m_done, m_sclk, m_sclrn, m_sout, m_en;

   int         n_assert = 0;
   int         n_fail   = 0;

   led_serializer #(.DATA_BITS(8), .CLK_DIV(2)) u_dut_a (
      .clk   (clk),
      .rst   (rst_a),
      .start (start_a),
      .pdata (pdata_a),
      .dir   (dir_a),
      .busy  (busy_a),
      .done  (done_a),
      .sclk  (sclk_a),
      .sclrn (sclrn_a),
      .sout  (sout_a),
      .en    (en_a)
   );

   led_serializer #(.DATA_BITS(16), .CLK_DIV(1)) u_dut_b (
      .clk   (clk),
      .rst   (rst_b),
      .start (start_b),
      .pdata (pdata_b),
      .dir   (dir_b),
      .busy  (busy_b),
      .done  (done_b),
      .sclk  (sclk_b),
      .sclrn (sclrn_b),
      .sout  (sout_b),
      .en    (en_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      if (sel != 0) begin
         m_busy = busy_b; m_done = done_b; m_sclk = sclk_b;
         m_sclrn = sclrn_b; m_sout = sout_b; m_en = en_b;
      end else begin
         m_busy = busy_a; m_done = done_a; m_sclk = sclk_a;
         m_sclrn = sclrn_a; m_sout = sout_a; m_en = en_a;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [5:0] outs();
      return {m_busy, m_done, m_sclk, m_sclrn, m_sout, m_en};
   endfunction

   // One frame on the selected instance. poke_k >= 0 pulses start and scrambles
   // pdata/dir mid-frame; rst_rise > 0 resets the DUT after that many sclk rises.
   task automatic frame(input int sel_i, input logic [15:0] pd, input logic d,
                        input int poke_k, input int rst_rise);
      int   nd, cd, k, rises, last_rise, sclrn_low, en_high, k_done, limit;
      logic prev_sclk, prev_sout, quiet, exp_bit;
      logic got[$];
      nd = (sel_i != 0) ? 16 : 8;
      cd = (sel_i != 0) ? 1 : 2;
      limit = cd * (2 * nd + 2) + 20;
      sel = sel_i;
      if (sel_i != 0) begin pdata_b = pd; dir_b = d; start_b = 1'b1; end
      else begin pdata_a = pd[7:0]; dir_a = d; start_a = 1'b1; end
      @(negedge clk);
      check("accept_busy", m_busy, 1);
      start_a = 1'b0; start_b = 1'b0;
      k = 0; rises = 0; last_rise = 0; sclrn_low = 0; en_high = 0; k_done = -1;
      prev_sclk = 1'b0; prev_sout = 1'b0;
      while (k_done < 0 && k <= limit) begin
         if (!m_sclrn) begin
            sclrn_low++;
            check("clear_quiet", {m_sclk, m_sout}, 0);
         end
         if (m_en) begin
            en_high++;
            check("latch_quiet", {m_sclk, m_sout, m_sclrn}, 1);
         end
         if (m_sclk && !prev_sclk) begin
            check("sout_stable_at_rise", m_sout, prev_sout);
            if (rises == 0) check("first_rise_time", k, 2 * cd);
            else            check("sclk_period", k - last_rise, 2 * cd);
            got.push_back(m_sout);
            last_rise = k;
            rises++;
         end
         if (rst_rise > 0 && rises == rst_rise) begin
            if (sel_i != 0) rst_b = 1'b1; else rst_a = 1'b1;
            #1;
            check("rst_async_outputs", outs(), 6'b000100);
            @(negedge clk);
            check("rst_held_outputs", outs(), 6'b000100);
            rst_a = 1'b0; rst_b = 1'b0;
            quiet = 1'b1;
            repeat (4 * cd * nd) begin
               @(negedge clk);
               if (m_busy || m_done) quiet = 1'b0;
            end
            check("rst_no_done_no_restart", quiet, 1);
            return;
         end
         if (m_done) begin
            k_done = k;
            check("done_not_busy", m_busy, 0);
         end else begin
            if (poke_k >= 0 && k >= poke_k) begin
               if (sel_i != 0) begin
                  pdata_b = 16'($urandom); dir_b = ~d; start_b = (k == poke_k);
               end else begin
                  pdata_a = 8'($urandom); dir_a = ~d; start_a = (k == poke_k);
               end
            end
            prev_sclk = m_sclk;
            prev_sout = m_sout;
            @(negedge clk);
            k++;
         end
      end
      start_a = 1'b0; start_b = 1'b0;
      check("latency", k_done, cd * (2 * nd + 2) + 1);
      check("sclrn_low_cycles", sclrn_low, cd);
      check("en_high_cycles", en_high, cd);
      check("bit_count", got.size(), nd);
      for (int i = 0; i < nd && i < got.size(); i++) begin
         exp_bit = d ? pd[i] : pd[nd - 1 - i];
         check($sformatf("bit%0d", i), got[i], exp_bit);
      end
      @(negedge clk);
      check("done_one_cycle", {m_done, m_busy}, 0);
      if (poke_k >= 0) begin
         quiet = 1'b1;
         repeat (20) begin
            @(negedge clk);
            if (m_busy) quiet = 1'b0;
         end
         check("no_queued_frame", quiet, 1);
      end
   endtask

   initial begin
      int   period, exp_frames, dones, frames, low_run;
      logic prev_busy;

      sel = 0;
      rst_a = 1'b1; rst_b = 1'b1;
      start_a = 1'b0; start_b = 1'b0;
      pdata_a = '0; pdata_b = '0; dir_a = 1'b0; dir_b = 1'b0;
      repeat (2) @(negedge clk);
      start_a = 1'b1; start_b = 1'b1;
      @(negedge clk);
      check("reset_a", {busy_a, done_a, sclk_a, sclrn_a, sout_a, en_a}, 6'b000100);
      check("reset_b", {busy_b, done_b, sclk_b, sclrn_b, sout_b, en_b}, 6'b000100);
      start_a = 1'b0; start_b = 1'b0;
      rst_a = 1'b0; rst_b = 1'b0;
      @(negedge clk);
      check("idle_after_reset_a", {busy_a, done_a, sclk_a, sclrn_a, sout_a, en_a}, 6'b000100);

      frame(0, 16'h00A5, 1'b0, -1, 0);
      frame(0, 16'h00A5, 1'b1, -1, 0);
      frame(0, 16'h0001, 1'b1, -1, 0);
      frame(0, 16'h003C, 1'b0, 10, 0);

      // Start held high for 100 cycles: frames every (latency + 1) cycles.
      sel = 0;
      period = 2 * (2 * 8 + 2) + 2;
      exp_frames = (100 + period - 1) / period;
      dones = 0; frames = 0; low_run = 0; prev_busy = 1'b0;
      pdata_a = 8'($urandom); dir_a = 1'($urandom);
      start_a = 1'b1;
      for (int c = 0; c < 180; c++) begin
         @(negedge clk);
         if (c == 99) start_a = 1'b0;
         if (m_done) dones++;
         if (m_busy && !prev_busy) begin
            frames++;
            if (frames > 1) check("b2b_idle_gap", low_run, 1);
            low_run = 0;
         end
         if (!m_busy) low_run++;
         prev_busy = m_busy;
      end
      check("b2b_frames", frames, exp_frames);
      check("b2b_dones", dones, exp_frames);

      frame(0, 16'($urandom), 1'b0, -1, 5);
      frame(0, 16'($urandom), 1'($urandom), -1, 0);

      frame(1, 16'h8001, 1'b0, -1, 0);
      frame(1, 16'($urandom), 1'b1, 3, 0);

      for (int i = 0; i < 8; i++) begin
         frame(int'($urandom_range(0, 1)), 16'($urandom), 1'($urandom), -1, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
